// File: rtl/fa_exhaustive_checker_if.sv
// Bundle of the sweep control, adder-under-test connections and result signals.
// The checker takes the slave side; whatever starts sweeps and models the adder takes the master side.
interface fa_exhaustive_checker_if;
  logic       start;
  logic       abort;
  logic       s_in;
  logic       cout_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [7:0] fail_map;
  logic [2:0] first_fail;

  modport slave (
    input  start, abort, s_in, cout_in,
    output a_out, b_out, c_out, busy, done, pass, err_count, fail_map, first_fail
  );

  modport master (
    output start, abort, s_in, cout_in,
    input  a_out, b_out, c_out, busy, done, pass, err_count, fail_map, first_fail
  );
endinterface

// File: rtl/fa_exhaustive_checker.sv
// Exhaustive full-adder checker: drives all eight operand vectors, waits a settle time,
// and compares the adder's sum/carry against the reference, recording per-vector failures.
module fa_exhaustive_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  fa_exhaustive_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state,      w_state_nxt;
  logic [2:0] r_idx,        w_idx_nxt;
  logic [2:0] r_abc,        w_abc_nxt;
  logic [3:0] r_settle,     w_settle_nxt;
  logic [3:0] r_err_count,  w_err_nxt;
  logic [7:0] r_fail_map,   w_map_nxt;
  logic [2:0] r_first_fail, w_first_nxt;

  logic w_exp_s;
  logic w_exp_cout;
  logic w_mismatch;

  // r_abc is {a,b,c}; reference sum is parity, reference carry is majority.
  assign w_exp_s    = ^r_abc;
  assign w_exp_cout = (r_abc[2] & r_abc[1]) | (r_abc[2] & r_abc[0]) | (r_abc[1] & r_abc[0]);
  assign w_mismatch = (bus.s_in != w_exp_s) || (bus.cout_in != w_exp_cout);

  always_comb begin
    // NOTE: every next-state variable takes its current value first so no path leaves it unassigned (no latches).
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_abc_nxt    = r_abc;
    w_settle_nxt = r_settle;
    w_err_nxt    = r_err_count;
    w_map_nxt    = r_fail_map;
    w_first_nxt  = r_first_fail;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt  = S_DRIVE;
          w_idx_nxt    = 3'd0;
          w_abc_nxt    = 3'd0;
          w_settle_nxt = 4'd0;
          w_err_nxt    = 4'd0;
          w_map_nxt    = 8'd0;
          w_first_nxt  = 3'd0;
        end
      end

      S_DRIVE: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 3'd0;
          w_abc_nxt   = 3'd0;
        end else if (r_settle == SETTLE_LAST) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_settle_nxt = r_settle + 4'd1;
        end
      end

      S_SAMPLE: begin
        // An abort in the sample cycle discards that vector's comparison.
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 3'd0;
          w_abc_nxt   = 3'd0;
        end else begin
          if (w_mismatch) begin
            w_err_nxt        = r_err_count + 4'd1;
            w_map_nxt[r_idx] = 1'b1;
            if (r_err_count == 4'd0) w_first_nxt = r_idx;
          end
          if (r_idx == 3'd7) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt  = S_DRIVE;
            w_idx_nxt    = r_idx + 3'd1;
            w_abc_nxt    = r_idx + 3'd1;
            w_settle_nxt = 4'd0;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_abc        <= 3'd0;
      r_settle     <= 4'd0;
      r_err_count  <= 4'd0;
      r_fail_map   <= 8'd0;
      r_first_fail <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_abc        <= w_abc_nxt;
      r_settle     <= w_settle_nxt;
      r_err_count  <= w_err_nxt;
      r_fail_map   <= w_map_nxt;
      r_first_fail <= w_first_nxt;
    end
  end

  assign bus.a_out      = r_abc[2];
  assign bus.b_out      = r_abc[1];
  assign bus.c_out      = r_abc[0];
  assign bus.busy       = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.pass       = (r_state == S_DONE) && (r_err_count == 4'd0);
  assign bus.err_count  = r_err_count;
  assign bus.fail_map   = r_fail_map;
  assign bus.first_fail = r_first_fail;

endmodule
